multicycle_control: RTL and testbench



---
 rtl/cpu_pkg.sv | 13 +
 rtl/multicycle_control_if.sv | 34 +++
 rtl/mem_wait_timer.sv | 21 ++
 rtl/multicycle_control.sv | 129 ++++++++++++
 tb/tb_multicycle_control.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer states and sign-extension helper shared by the CPU control path.
package cpu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    function automatic logic [7:0] sext(input logic [5:0] v);
        return {{2{v[5]}}, v};
    endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction fetch, data-memory handshake and register-file control bundle.
interface multicycle_control_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        instruction;
    logic              imem_valid;
    logic              mem_ready;
    logic              imem_req;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        read_register1;
    logic [1:0]        read_register2;
    logic [1:0]        destination_register;
    logic              regdst;
    logic              regwrite;
    logic              memtoreg;
    logic              alu_src;
    logic [7:0]        imm_ext;
    logic              mem_read;
    logic              mem_write;
    logic              error;
    logic [2:0]        state;

    modport master (
        input  instruction, imem_valid, mem_ready,
        output imem_req, pc, read_register1, read_register2, destination_register,
               regdst, regwrite, memtoreg, alu_src, imm_ext, mem_read, mem_write, error, state
    );

    modport slave (
        output instruction, imem_valid, mem_ready,
        input  imem_req, pc, read_register1, read_register2, destination_register,
               regdst, regwrite, memtoreg, alu_src, imm_ext, mem_read, mem_write, error, state
    );
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on data memory and flags expiry at WAIT_LIMIT.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = $clog2(WAIT_LIMIT + 1);

    logic [W-1:0] r_count;

    assign o_expired = r_count == W'(WAIT_LIMIT);

    always_ff @(posedge CLK) begin
        if (RESET || i_clear) r_count <= '0;
        else if (i_enable && !o_expired) r_count <= r_count + W'(1);
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/mem/write-back sequencer for the 8-bit CPU.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int WAIT_LIMIT = 15
) (
    input  logic CLK,
    input  logic RESET,
    multicycle_control_if.master bus
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_ir;
    logic              r_imem_req;
    logic              r_regwrite;
    logic              r_regdst;
    logic              r_memtoreg;
    logic              r_alu_src;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_error;
    logic [1:0]        w_op;
    logic              w_expired;
    logic [ADDR_W-1:0] w_jump_target;

    assign w_op          = r_ir[7:6];
    assign w_jump_target = r_pc + ADDR_W'(signed'(sext(r_ir[5:0])));

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_clear   (r_state != MEM),
        .i_enable  (r_state == MEM),
        .o_expired (w_expired)
    );

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= FETCH;
            r_pc        <= '0;
            r_ir        <= '0;
            r_error     <= 1'b0;
            r_imem_req  <= 1'b1;
            r_regwrite  <= 1'b0;
            r_regdst    <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_alu_src   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_imem_req  <= 1'b0;
            r_regwrite  <= 1'b0;
            r_regdst    <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_alu_src   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                FETCH: begin
                    r_imem_req <= !bus.imem_valid;
                    if (bus.imem_valid) begin
                        r_ir    <= bus.instruction;
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    if (w_op == OP_JMP) begin
                        r_pc       <= w_jump_target;
                        r_state    <= FETCH;
                        r_imem_req <= 1'b1;
                    end else begin
                        r_state   <= EXEC;
                        r_alu_src <= w_op != OP_ADD;
                    end
                end
                EXEC: begin
                    r_state     <= (w_op == OP_ADD) ? WB : MEM;
                    r_regwrite  <= w_op == OP_ADD;
                    r_regdst    <= w_op == OP_ADD;
                    r_alu_src   <= w_op != OP_ADD;
                    r_mem_read  <= w_op == OP_LW;
                    r_mem_write <= w_op == OP_SW;
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        r_state    <= (w_op == OP_LW) ? WB : FETCH;
                        r_regwrite <= w_op == OP_LW;
                        r_memtoreg <= w_op == OP_LW;
                        r_imem_req <= w_op != OP_LW;
                    end else if (w_expired) begin
                        r_error    <= 1'b1;
                        r_state    <= FETCH;
                        r_imem_req <= 1'b1;
                    end else begin
                        r_alu_src   <= 1'b1;
                        r_mem_read  <= w_op == OP_LW;
                        r_mem_write <= w_op == OP_SW;
                    end
                end
                WB: begin
                    r_state    <= FETCH;
                    r_imem_req <= 1'b1;
                end
                default: begin
                    r_state    <= FETCH;
                    r_imem_req <= 1'b1;
                end
            endcase
        end
    end

    assign bus.imem_req             = r_imem_req;
    assign bus.pc                   = r_pc;
    assign bus.read_register1       = r_ir[5:4];
    assign bus.read_register2       = r_ir[3:2];
    assign bus.destination_register = r_ir[1:0];
    assign bus.regdst               = r_regdst;
    assign bus.regwrite             = r_regwrite;
    assign bus.memtoreg             = r_memtoreg;
    assign bus.alu_src              = r_alu_src;
    assign bus.imm_ext              = {{6{r_ir[1]}}, r_ir[1:0]};
    assign bus.mem_read             = r_mem_read;
    assign bus.mem_write            = r_mem_write;
    assign bus.error                = r_error;
    assign bus.state                = r_state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream checked by a queue scoreboard against an ISA-level model.
module tb_multicycle_control;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.ADDR_W(8)) bus ();

    multicycle_control #(.ADDR_W(8), .WAIT_LIMIT(15)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.master)
    );

    typedef struct packed {logic [7:0] pc; logic err;} fetch_t;
    typedef struct packed {logic regdst; logic memtoreg; logic [1:0] rd; logic [1:0] rs; logic [1:0] rt;} wb_t;
    typedef struct packed {logic wr; logic [4:0] cycles; logic [1:0] rs; logic [1:0] rt; logic [7:0] imm; logic alu_src;} mem_t;

    fetch_t q_fetch[$];
    wb_t    q_wb[$];
    mem_t   q_mem[$];
    int     checks = 0;
    int     failures = 0;
    int     m_pc = 0;
    logic   m_err = 1'b0;
    int     mon_cnt = 0;
    fetch_t mf;
    wb_t    mw;
    mem_t   mm;
    mem_t   cap;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops the scoreboard whenever the DUT fetches, writes back or finishes a memory access.
    initial forever begin
        @(negedge clk);
        if (rst) mon_cnt = 0;
        else begin
            if (bus.imem_req && bus.imem_valid) begin
                chk("fetch_expected", q_fetch.size() != 0, 1);
                if (q_fetch.size() != 0) begin
                    mf = q_fetch.pop_front();
                    chk("fetch_pc", bus.pc, mf.pc);
                    chk("fetch_error", bus.error, mf.err);
                end
            end
            if (bus.regwrite) begin
                chk("wb_expected", q_wb.size() != 0, 1);
                chk("wb_mem_overlap", bus.mem_read | bus.mem_write, 0);
                if (q_wb.size() != 0) begin
                    mw = q_wb.pop_front();
                    chk("wb_regdst", bus.regdst, mw.regdst);
                    chk("wb_memtoreg", bus.memtoreg, mw.memtoreg);
                    chk("wb_rd", bus.destination_register, mw.rd);
                    chk("wb_rs", bus.read_register1, mw.rs);
                    chk("wb_rt", bus.read_register2, mw.rt);
                end
            end
            if (bus.mem_read || bus.mem_write) begin
                if (mon_cnt == 0) begin
                    cap.wr      = bus.mem_write;
                    cap.rs      = bus.read_register1;
                    cap.rt      = bus.read_register2;
                    cap.imm     = bus.imm_ext;
                    cap.alu_src = bus.alu_src;
                end
                chk("mem_single_request", bus.mem_read & bus.mem_write, 0);
                mon_cnt++;
            end else if (mon_cnt != 0) begin
                chk("mem_expected", q_mem.size() != 0, 1);
                if (q_mem.size() != 0) begin
                    mm = q_mem.pop_front();
                    chk("mem_kind", cap.wr, mm.wr);
                    chk("mem_cycles", mon_cnt, mm.cycles);
                    chk("mem_rs", cap.rs, mm.rs);
                    chk("mem_rt", cap.rt, mm.rt);
                    chk("mem_imm", cap.imm, mm.imm);
                    chk("mem_alu_src", cap.alu_src, mm.alu_src);
                end
                mon_cnt = 0;
            end
        end
    end

    task automatic wait_req();
        int n;
        n = 0;
        while (!bus.imem_req && n < 60) begin
            step();
            n++;
        end
        chk("imem_req_within_bound", bus.imem_req, 1);
    endtask

    task automatic mem_phase(input int d, input int abort);
        int n;
        n = 0;
        while (!(bus.mem_read || bus.mem_write) && n < 10) begin
            step();
            n++;
        end
        chk("mem_req_within_bound", bus.mem_read | bus.mem_write, 1);
        if (abort >= 0) begin
            repeat (abort) step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("abort_state", bus.state, FETCH);
            chk("abort_mem_read", bus.mem_read, 0);
            chk("abort_regwrite", bus.regwrite, 0);
            chk("abort_error", bus.error, 0);
            chk("abort_pc", bus.pc, 0);
            m_pc = 0;
            m_err = 1'b0;
        end else begin
            for (int i = 0; i <= 15; i++) begin
                bus.mem_ready = (i == d);
                step();
                if (i == d) break;
            end
            bus.mem_ready = 1'b0;
        end
    endtask

    // Model: ISA semantics with plain arithmetic; timeouts are any wait longer than 15 cycles.
    task automatic issue(input logic [7:0] ins, input int d, input int abort);
        logic [1:0] op;
        int         off;
        int         imm;
        fetch_t     f;
        wb_t        w;
        mem_t       m;
        op = ins[7:6];
        wait_req();
        repeat ($urandom_range(0, 2)) step();
        f.pc = 8'(m_pc);
        f.err = m_err;
        q_fetch.push_back(f);
        m_pc = (m_pc + 1) & 255;
        if (op == 2'b11) begin
            off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
            m_pc = (m_pc + off) & 255;
        end
        w.rd = ins[1:0];
        w.rs = ins[5:4];
        w.rt = ins[3:2];
        if (op == 2'b00) begin
            w.regdst = 1'b1;
            w.memtoreg = 1'b0;
            q_wb.push_back(w);
        end
        if ((op == 2'b01 || op == 2'b10) && abort < 0) begin
            imm = ins[1] ? int'(ins[1:0]) - 4 : int'(ins[1:0]);
            m.wr = op == 2'b10;
            m.cycles = (d <= 15) ? 5'(d + 1) : 5'd16;
            m.rs = ins[5:4];
            m.rt = ins[3:2];
            m.imm = 8'(imm & 255);
            m.alu_src = 1'b1;
            q_mem.push_back(m);
            if (d > 15) m_err = 1'b1;
            else if (op == 2'b01) begin
                w.regdst = 1'b0;
                w.memtoreg = 1'b1;
                q_wb.push_back(w);
            end
        end
        bus.instruction = ins;
        bus.imem_valid = 1'b1;
        step();
        bus.imem_valid = 1'b0;
        bus.instruction = 8'($urandom);
        if (op == 2'b01 || op == 2'b10) mem_phase(d, abort);
    endtask

    initial begin
        bus.instruction = 8'h00;
        bus.imem_valid = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_state", bus.state, FETCH);
        chk("reset_pc", bus.pc, 0);
        chk("reset_regwrite", bus.regwrite, 0);
        chk("reset_error", bus.error, 0);
        chk("reset_imem_req", bus.imem_req, 1);
        chk("reset_mem_req", bus.mem_read | bus.mem_write, 0);
        issue(8'b00_01_10_11, 0, -1);
        issue(8'b01_00_01_10, 3, -1);
        issue(8'b10_00_01_01, 20, -1);
        wait_req();
        chk("timeout_error", bus.error, 1);
        issue(8'b00_11_00_01, 0, -1);
        issue(8'b00_10_10_00, 0, -1);
        issue(8'b11_111110, 0, -1);
        chk("jmp_pc_after_fetch", bus.pc, 6);
        step();
        chk("jmp_pc_after_decode", bus.pc, 4);
        chk("jmp_back_to_fetch", bus.imem_req, 1);
        issue(8'b01_01_10_11, 20, 3);
        issue(8'b11_111110, 0, -1);
        step();
        chk("pc_before_wrap", bus.pc, 8'hFF);
        issue(8'b00_00_01_10, 0, -1);
        chk("pc_wrap", bus.pc, 0);
        for (int k = 0; k < 60; k++) issue(8'($urandom), $urandom_range(0, 18), -1);
        wait_req();
        repeat (3) step();
        chk("fetch_queue_drained", q_fetch.size(), 0);
        chk("wb_queue_drained", q_wb.size(), 0);
        chk("mem_queue_drained", q_mem.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
